// File: rtl/mult_div_unit.sv
// ============================================================================
// mult_div_unit : iterative MULT/MULTU/DIV/DIVU unit with HI/LO result regs
// Revision      : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_src_a,
    input  logic [WIDTH-1:0] i_src_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int              CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a_orig;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;
    logic               r_res_neg;
    logic               r_rem_neg;
    logic               r_b_zero;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_sub;
    logic [WIDTH-1:0]   w_quo;

    assign w_a_neg = i_op[0] & i_src_a[WIDTH-1];
    assign w_b_neg = i_op[0] & i_src_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -i_src_a : i_src_a;
    assign w_b_mag = w_b_neg ? -i_src_b : i_src_b;

    // Multiply: r_opnd is the multiplicand, low half of r_acc the multiplier.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{r_acc[0]}} & r_opnd};

    // Divide: r_opnd is the divisor, low half of r_acc shifts dividend out / quotient in.
    assign w_div_shift = {r_rem, r_acc[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_sub   = WIDTH'(w_div_shift - {1'b0, r_opnd});
    assign w_quo       = r_acc[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_op          <= '0;
            r_a_orig      <= '0;
            r_opnd        <= '0;
            r_acc         <= '0;
            r_rem         <= '0;
            r_res_neg     <= 1'b0;
            r_rem_neg     <= 1'b0;
            r_b_zero      <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_div_by_zero <= 1'b0;
            o_hi          <= '0;
            o_lo          <= '0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state   <= S_CALC;
                        r_cnt     <= '0;
                        r_op      <= i_op;
                        r_a_orig  <= i_src_a;
                        r_opnd    <= i_op[1] ? w_b_mag : w_a_mag;
                        r_acc     <= {{WIDTH{1'b0}}, (i_op[1] ? w_a_mag : w_b_mag)};
                        r_rem     <= '0;
                        r_res_neg <= w_a_neg ^ w_b_neg;
                        r_rem_neg <= w_a_neg;
                        r_b_zero  <= (i_src_b == '0);
                        o_busy    <= 1'b1;
                    end
                end
                S_CALC: begin
                    if (r_op[1]) begin
                        r_rem <= w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
                        r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_div_ge};
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b1;
                    if (!r_op[1]) begin
                        {o_hi, o_lo}  <= r_res_neg ? -r_acc : r_acc;
                        o_div_by_zero <= 1'b0;
                    end else if (r_b_zero) begin
                        o_hi          <= r_a_orig;
                        o_lo          <= '1;
                        o_div_by_zero <= 1'b1;
                    end else begin
                        o_lo          <= r_res_neg ? -w_quo : w_quo;
                        o_hi          <= r_rem_neg ? -r_rem : r_rem;
                        o_div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the MIPS single-cycle core, parametrised in operand width. It executes MULT, MULTU, DIV and DIVU and holds the results in dedicated HI/LO registers. It sits beside the combinational ALU. The control block stalls the PC while `busy` is high, and reads HI/LO for MFHI/MFLO.

## Interface
- `WIDTH`, default 32: operand width in bits. Must be ≥ 4. HI and LO are each `WIDTH` bits.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request. Sampled only in IDLE.
- `op`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `src_a`  in  WIDTH  multiplicand or dividend (rs).
- `src_b`  in  WIDTH  multiplier or divisor (rt).
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse: HI/LO are valid and newly updated.
- `div_by_zero`  out  1  valid with `done`. Set when a DIV/DIVU had `src_b`==0.
- `hi`  out  WIDTH  upper product half, or remainder.
- `lo`  out  WIDTH  lower product half, or quotient.

## Operation
- States are IDLE, CALC and FIX. Reset forces IDLE and an iteration counter of 0. It also forces `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0 and `lo`=0.
- **IDLE → CALC** occurs on `start`=1.
  - `op`, `src_a` and `src_b` are latched at that edge. Later changes to the inputs are ignored.
  - For signed ops, the operand magnitudes are latched, along with the result sign (a_sign XOR b_sign) and the remainder sign (a_sign).
- **CALC** runs exactly `WIDTH` iterations, one per cycle, counted from 0 to WIDTH-1.
  - Multiply: radix-2 shift-add into a 2·WIDTH accumulator, LSB-first over the multiplier magnitude.
  - Divide: restoring division. A WIDTH+1-bit partial remainder shifts in one dividend bit per cycle, MSB-first, with a trial subtract; the quotient bit = NOT borrow.
- **CALC → FIX** occurs after the last iteration. **FIX → IDLE** takes one cycle.
- **FIX** writes HI/LO. It asserts `done` and loads `div_by_zero` for the following cycle.
  - MULT: two's-complement negate the 2·WIDTH product if the result sign is set.
  - DIV: negate the quotient if the result sign is set; negate the remainder if the remainder sign is set. The remainder sign follows the dividend.
  - Divide by zero, signed or unsigned: `hi` = latched original `src_a`, `lo` = all ones, `div_by_zero`=1. The latency is unchanged.
  - Signed overflow, most-negative ÷ −1: `lo` = most-negative, `hi` = 0, `div_by_zero`=0. This falls out of the magnitude algorithm; no special case is needed.
- `hi` and `lo` change only in FIX or on reset. They hold their values between operations.
- `div_by_zero` is cleared in FIX for multiplies and non-zero divides. It holds its value until the next FIX.

## Timing
- `start` is accepted at edge k. `busy`=1 from the cycle after edge k through the cycle containing edge k+WIDTH+1, which is WIDTH+1 cycles in total.
- `done`=1, `busy`=0 and the new HI/LO values are visible in the cycle after edge k+WIDTH+1. The total latency is WIDTH+2 cycles from the start cycle.
- `done` is high for exactly one cycle.
- `start` while `busy`=1 is ignored; no queueing.
- `start` during the `done` cycle is accepted, since the state is IDLE. This allows back-to-back operations with no gap.
- Reset mid-CALC or in FIX takes effect at the next edge:
  - state returns to IDLE;
  - HI/LO return to 0;
  - no `done` is produced.
- Reset and `start` asserted in the same cycle: reset wins.

## Test plan
- MULTU: 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. `done` appears 34 cycles after the start cycle, and `busy` is high for 33 cycles.
- MULT: −3 × 5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. MULT −1 × −1 → `hi`=0, `lo`=1.
- DIVU 100 ÷ 7 → `lo`=14, `hi`=2. DIV −7 ÷ 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 0x80000000 ÷ 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU 0x1234 ÷ 0 → `hi`=0x1234, `lo`=0xFFFFFFFF, `div_by_zero`=1. A following MULTU 2×3 → `lo`=6, `hi`=0, `div_by_zero`=0.
- Change `src_a`/`src_b` and pulse `start` mid-operation → result matches the originally latched operands, and only one `done` is produced. A `start` issued in the `done` cycle → the second `done` arrives exactly 34 cycles later.
- Reset asserted at iteration 10 of a DIVU → the next cycle has `busy`=0, `hi`=`lo`=0, and no `done` ever appears. Repeat all vectors with `WIDTH`=8, e.g. MULTU 0xFF×0xFF → `hi`=0xFE, `lo`=0x01, with latency 10.
